// File: rtl/gate_chk_pkg.sv
// Shared types, constants and golden model for the four-input gate response checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned SIG_W     = 16;
    localparam int unsigned VEC_W     = 4;
    localparam int unsigned OUT_W     = 3;
    localparam int unsigned SCNT_W    = 8;
    localparam logic [15:0] MISR_POLY = 16'h1021;

    // Expected {g,f,e} for a stimulus vector {d,c,b,a}.
    function automatic logic [2:0] gate_golden(input logic [3:0] vec);
        logic e;
        logic f;
        logic g;
        e = ~(vec[0] & vec[1]);
        f = ~(vec[2] & vec[3]);
        g = ~(&vec);
        return {g, f, e};
    endfunction

endpackage

// File: rtl/gate_chk_misr.sv
// 16-bit MISR compressing {dut_out, vec_in} of every accepted sample.
module gate_chk_misr
    import gate_chk_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [6:0]  data_i,
    output logic [15:0] sig_o
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000)
                  ^ {9'b0, data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/gate_resp_checker.sv
// Response checker for the four-input gate lab: golden compare, error count, coverage, pass/fail.
// Optional MISR signature built only when GATE_CHK_MISR_EN is defined.
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned NVEC  = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [3:0]       vec_in,
    input  logic [2:0]       dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       first_err_idx,
    output logic [15:0]      signature
);

    localparam logic [CNT_W-1:0]  ERR_MAX  = {CNT_W{1'b1}};
    localparam logic [SCNT_W-1:0] LAST_CNT = SCNT_W'(NVEC);

    state_e             state_q, state_d;
    logic [SCNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [3:0]         first_q, first_d;
    logic [15:0]        cov_q, cov_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               clear_c;
    logic               sample_en_c;
    logic               mismatch_c;

    assign mismatch_c = (dut_out != gate_golden(vec_in));

    // Next-state and sweep bookkeeping; start clears results in the same cycle it is taken.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        first_d     = first_q;
        cov_d       = cov_q;
        pass_d      = pass_q;
        clear_c     = 1'b0;
        sample_en_c = 1'b0;

        unique case (state_q)
            ST_IDLE: if (start) begin
                clear_c = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: if (vec_valid) begin
                sample_en_c = 1'b1;
            end
            ST_DONE: if (start) begin
                clear_c = 1'b1;
                state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear_c) begin
            cnt_d   = '0;
            err_d   = '0;
            first_d = '0;
            cov_d   = '0;
            pass_d  = 1'b0;
        end

        if (sample_en_c) begin
            cnt_d = cnt_q + SCNT_W'(1);
            cov_d = cov_q | (16'd1 << vec_in);
            if (mismatch_c) begin
                if (err_q != ERR_MAX) begin
                    err_d = err_q + CNT_W'(1);
                end
                if (err_q == '0) begin
                    first_d = vec_in;
                end
            end
            if (cnt_d == LAST_CNT) begin
                state_d = ST_DONE;
                pass_d  = (err_d == '0) & (&cov_d);
            end
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            cov_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            first_q <= first_d;
            cov_q   <= cov_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_q;
    assign first_err_idx = first_q;

`ifdef GATE_CHK_MISR_EN
    gate_chk_misr u_misr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clear_c),
        .en_i   (sample_en_c),
        .data_i ({dut_out, vec_in}),
        .sig_o  (signature)
    );
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_gate_resp_checker.sv
// Scoreboard bench for gate_resp_checker: default instance plus a CNT_W=2 instance for saturation.
module tb_gate_resp_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic        vec_valid;
    logic [3:0]  vec_in;
    logic [2:0]  dut_out;

    logic        busy, done, pass;
    logic [4:0]  err_cnt;
    logic [3:0]  first_err_idx;
    logic [15:0] signature;

    logic        s_busy, s_done, s_pass;
    logic [1:0]  s_err_cnt;
    logic [3:0]  s_first_err_idx;
    logic [15:0] s_signature;

    gate_resp_checker #(.NVEC(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
        .vec_in(vec_in), .dut_out(dut_out), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
        .signature(signature)
    );

    gate_resp_checker #(.NVEC(16), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
        .vec_in(vec_in), .dut_out(dut_out), .busy(s_busy), .done(s_done),
        .pass(s_pass), .err_cnt(s_err_cnt), .first_err_idx(s_first_err_idx),
        .signature(s_signature)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic        done;
        logic        pass;
        logic [4:0]  err;
        logic [1:0]  err2;
        logic [3:0]  first;
        logic [15:0] sig;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: 0 idle, 1 run, 2 done.
    int          m_st;
    int          m_cnt;
    int          m_err;
    int          m_err2;
    logic [3:0]  m_first;
    logic [15:0] m_cov;
    logic [15:0] m_sig;
    logic        m_pass;
    logic [15:0] sig_golden;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] golden(input logic [3:0] v);
        logic a, b, c, d;
        {d, c, b, a} = v;
        return {!(a && b && c && d), !(c && d), !(a && b)};
    endfunction

    task automatic model_clear();
        m_cnt   = 0;
        m_err   = 0;
        m_err2  = 0;
        m_first = 4'h0;
        m_cov   = 16'h0;
        m_sig   = 16'h0;
        m_pass  = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic s, input logic v,
                              input logic [3:0] vi, input logic [2:0] o);
        if (r) begin
            model_clear();
            m_st = 0;
        end else if (m_st == 1) begin
            if (v) begin
                m_cnt++;
                m_cov[vi] = 1'b1;
                if (o != golden(vi)) begin
                    if (m_err == 0) m_first = vi;
                    if (m_err < 31) m_err++;
                    if (m_err2 < 3) m_err2++;
                end
`ifdef GATE_CHK_MISR_EN
                m_sig = {m_sig[14:0], 1'b0} ^ (m_sig[15] ? 16'h1021 : 16'h0000) ^ {9'b0, o, vi};
`endif
                if (m_cnt == 16) begin
                    m_st   = 2;
                    m_pass = (m_err == 0) && (m_cov == 16'hFFFF);
                end
            end
        end else if (s) begin
            model_clear();
            m_st = 1;
        end
    endtask

    task automatic do_cycle(input logic r, input logic s, input logic v,
                            input logic [3:0] vi, input logic [2:0] o);
        exp_t e;
        rst = r; start = s; vec_valid = v; vec_in = vi; dut_out = o;
        model_step(r, s, v, vi, o);
        e.busy  = (m_st == 1);
        e.done  = (m_st == 2);
        e.pass  = (m_st == 2) && m_pass;
        e.err   = 5'(m_err);
        e.err2  = 2'(m_err2);
        e.first = m_first;
        e.sig   = m_sig;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("busy",      32'(busy),            32'(e.busy));
            check("done",      32'(done),            32'(e.done));
            check("pass",      32'(pass),            32'(e.pass));
            check("err_cnt",   32'(err_cnt),         32'(e.err));
            check("first_err", 32'(first_err_idx),   32'(e.first));
            check("signature", 32'(signature),       32'(e.sig));
            check("sat_busy",  32'(s_busy),          32'(e.busy));
            check("sat_done",  32'(s_done),          32'(e.done));
            check("sat_pass",  32'(s_pass),          32'(e.pass));
            check("sat_err",   32'(s_err_cnt),       32'(e.err2));
            check("sat_first", 32'(s_first_err_idx), 32'(e.first));
        end
    endtask

    // mode 0 golden, 1 e inverted at 5 and 9, 2 vec 7 replaced by 3,
    // 3 all wrong with gaps, 4 f flipped at vec 12.
    task automatic run_sweep(input int mode, input int nsamp);
        logic [3:0] vi;
        logic [2:0] o;
        do_cycle(1'b0, 1'b1, 1'b1, 4'hA, 3'b000);
        for (int i = 0; i < nsamp; i++) begin
            vi = 4'(i);
            if (mode == 2 && i == 7) vi = 4'd3;
            o = golden(vi);
            if (mode == 1 && (i == 5 || i == 9)) o = o ^ 3'b001;
            if (mode == 3) o = ~o;
            if (mode == 4 && i == 12) o = o ^ 3'b010;
            if (mode == 3) do_cycle(1'b0, 1'b0, 1'b0, 4'($urandom_range(15)), 3'($urandom_range(7)));
            do_cycle(1'b0, (mode == 1 && i == 8), 1'b1, vi, o);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_in = 4'h0; dut_out = 3'h0;
        m_st = 0;
        model_clear();
        sig_golden = 16'h0;

        do_cycle(1'b1, 1'b0, 1'b0, 4'h0, 3'h0);
        do_cycle(1'b1, 1'b0, 1'b0, 4'h0, 3'h0);
        // Samples in IDLE must be ignored.
        do_cycle(1'b0, 1'b0, 1'b1, 4'h3, 3'h0);
        do_cycle(1'b0, 1'b0, 1'b1, 4'h5, 3'h7);

        run_sweep(0, 16);
        sig_golden = signature;
        do_cycle(1'b0, 1'b0, 1'b1, 4'h1, 3'h0);
        do_cycle(1'b0, 1'b0, 1'b0, 4'h0, 3'h0);

        run_sweep(0, 16);
`ifdef GATE_CHK_MISR_EN
        check("sig_repeat", 32'(signature), 32'(sig_golden));
`endif
        run_sweep(1, 16);
        do_cycle(1'b0, 1'b0, 1'b0, 4'h0, 3'h0);
        run_sweep(2, 16);
        run_sweep(3, 16);
        do_cycle(1'b0, 1'b0, 1'b1, 4'h0, 3'h0);

        run_sweep(0, 8);
        do_cycle(1'b1, 1'b0, 1'b1, 4'h8, 3'h0);
        do_cycle(1'b0, 1'b0, 1'b1, 4'h9, 3'h0);
        run_sweep(0, 16);

        run_sweep(4, 16);
`ifdef GATE_CHK_MISR_EN
        check("sig_flip_differs", 32'(signature != sig_golden), 32'd1);
`endif
        do_cycle(1'b0, 1'b0, 1'b0, 4'h0, 3'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_resp_checker.md
# gate_resp_checker

Synthesizable response checker for the four-input gate lab: the receive-side counterpart of the exhaustive 4-bit stimulus sweep. Each cycle it samples the applied input vector {d,c,b,a} and the DUT's three outputs {g,f,e}, then compares them with a built-in golden model. It accumulates an error count, a vector-coverage bitmap and an optional MISR signature, and reports pass/fail at the end of a sweep. It sits beside the gate DUT on the board or in a bench, driven by the same clock as the stimulus counter.

## Interface
Parameters:
- NVEC, 16: samples per sweep (1..255).
- CNT_W, 5: width of the error counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep (ignored while busy).
- vec_valid  in  1  vec_in/dut_out valid this cycle.
- vec_in  in  4  applied stimulus {d,c,b,a}.
- dut_out  in  3  observed DUT outputs {g,f,e}.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until next start or rst.
- pass  out  1  valid when done: err_cnt==0 and all 16 vectors seen.
- err_cnt  out  CNT_W  mismatch count, saturating at 2^CNT_W-1.
- first_err_idx  out  4  vec_in of the first mismatch; 0 if none.
- signature  out  16  MISR value (see Configuration).

## Operation
- Golden model: e = ~(a&b); f = ~(c&d); g = ~(a&b&c&d).
- FSM states and transitions:
  - IDLE → RUN on start.
  - RUN → DONE when the NVEC-th valid sample is accepted.
  - DONE → RUN on start.
  - rst from any state → IDLE.
- Entering RUN clears err_cnt, first_err_idx, coverage bitmap, sample counter and signature in the same cycle as start; vec_valid on the start cycle is ignored.
- In RUN, each vec_valid cycle:
  - sample_cnt++.
  - coverage[vec_in] ← 1.
  - If dut_out ≠ expected: err_cnt++ (saturating); first_err_idx captured only on the first mismatch.
- Duplicate vectors are allowed. They count toward NVEC but do not add coverage.
- vec_valid is ignored in IDLE and DONE.
- pass = done & (err_cnt==0) & (&coverage). With NVEC<16, pass is therefore 0.

## Timing
- Reset values: busy=0, done=0, pass=0, err_cnt=0, first_err_idx=0, signature=0, state=IDLE.
- All outputs are registered.
- err_cnt, first_err_idx and signature reflect a sample 1 cycle after its vec_valid edge.
- busy rises the cycle after start.
- done and pass rise, and busy falls, the cycle after the last sample is accepted, with final counts stable in that same cycle.
- start in RUN is ignored.
- start in DONE: done drops and busy rises next cycle.
- rst mid-sweep aborts and discards all results; no done pulse is produced.
- Saturation: once err_cnt reaches its maximum, further mismatches hold it at the maximum.

## Configuration
- GATE_CHK_MISR_EN defined: a 16-bit MISR with polynomial x^16+x^12+x^5+1 updates on each accepted sample.
  - Update: sig ← {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {9'b0, dut_out, vec_in}.
  - Cleared on start and on rst.
- Undefined: signature tied to 16'h0000 and no MISR logic is built. All other behaviour is identical.

## Structure
- Shared package gate_chk_pkg holds:
  - state enum {ST_IDLE, ST_RUN, ST_DONE};
  - MISR_POLY = 16'h1021;
  - function gate_golden(vec) returning the 3-bit expected outputs.
- One sub-module, gate_chk_misr, holds the MISR register. It is instantiated only under GATE_CHK_MISR_EN.

## Test plan
- Golden sweep: rst, start, then 16 consecutive vec_valid with vec_in 0..15 and correct dut_out → done 1 cycle after the last sample; pass=1, err_cnt=0, first_err_idx=0.
- Injected faults: same sweep with e inverted at vec 5 and vec 9 → err_cnt=2, first_err_idx=5, pass=0.
- Coverage hole: 16 samples with vec 3 repeated twice and vec 7 never applied, all outputs correct → err_cnt=0, pass=0.
- Saturation and gaps: CNT_W=2, all 16 samples wrong, vec_valid deasserted every other cycle → err_cnt=3, done after the 16th valid sample only.
- Reset mid-sweep: rst after 8 samples → all outputs 0, state IDLE. A new start followed by a golden sweep gives pass=1.
- MISR (macro defined): golden sweep gives a fixed signature matching the bench model; repeating after start gives an identical value. One flipped dut_out bit changes the signature. Macro undefined: signature=0 throughout.
